// File: rtl/ctrl_pkg.sv
// Shared definitions for the lab03 fetch stage and control unit.
//   OP_JMP / OP_HLT : opcodes executed locally by the fetch stage
//   OP_MSB / OP_LSB : position of the opcode field in a 16-bit instruction word
//   fetch_state_t   : fetch/sequencer state encoding
//   get_opcode()    : extracts the opcode field from an instruction word
package ctrl_pkg;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 13;
  localparam int unsigned OP_W   = OP_MSB - OP_LSB + 1;

  localparam logic [OP_W-1:0] OP_JMP = 3'b110;
  localparam logic [OP_W-1:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StMem,
    StIssue,
    StExec,
    StHalted
  } fetch_state_t;

  function automatic logic [OP_W-1:0] get_opcode(input logic [15:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch/sequencer stage: walks pc through instruction memory, executes JMP and
// HLT locally and issues every other instruction to the control unit, holding
// it until the control unit reports done.
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   start        : begin execution at start_addr (only honoured when idle/halted)
//   start_addr   : first fetch address
//   imem_addr    : instruction-memory address (always equals pc)
//   imem_rd      : memory read strobe; data returns one cycle later
//   imem_rdata   : memory read data
//   instruction  : registered instruction presented to the control unit
//   run          : one-cycle issue pulse
//   done         : control unit finished the issued instruction (sampled in EXEC only)
//   pc           : current program counter
//   busy         : high in every state except IDLE and HALTED
//   halted       : high in HALTED
// The JMP target is taken from the low ADDR_W bits of the word, so ADDR_W <= 16.
module instr_fetch
  import ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instruction,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic              imem_rd_q, run_q, busy_q, halted_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      StIdle, StHalted: begin
        if (start) begin
          pc_d    = start_addr;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StMem;
      StMem: begin
        instr_d = imem_rdata;
        case (get_opcode(imem_rdata))
          OP_HLT:  state_d = StHalted;  // pc stays on the HLT word
          OP_JMP: begin
            pc_d    = imem_rdata[ADDR_W-1:0];
            state_d = StFetch;
          end
          default: state_d = StIssue;
        endcase
      end
      StIssue: begin
        pc_d    = pc_q + 1'b1;  // wraps modulo 2^ADDR_W
        state_d = StExec;
      end
      StExec: begin
        if (done) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they come straight off flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      instr_q   <= '0;
      imem_rd_q <= 1'b0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      imem_rd_q <= (state_d == StFetch);
      run_q     <= (state_d == StIssue);
      busy_q    <= (state_d != StIdle) && (state_d != StHalted);
      halted_q  <= (state_d == StHalted);
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign imem_rd     = imem_rd_q;
  assign run         = run_q;
  assign busy        = busy_q;
  assign halted      = halted_q;

endmodule
